// File: rtl/side_road_detector_if.sv
// side_road_detector_if: bundle between the side-road detector and its
// neighbours (raw loop input, light state in, request and status out).
// x is a level request, not a valid/ready handshake: it stays high while
// vehicles need service, EW is sampled every cycle, and no acknowledge exists.
interface side_road_detector_if #(
    parameter int QW = 4
);
    logic          car_in;
    logic [1:0]    EW;
    logic          x;
    logic [QW-1:0] queue_count;
    logic          overflow;
    logic [1:0]    state;

    // Environment side: drives the detector loop and the light state.
    modport master (
        output car_in, EW,
        input  x, queue_count, overflow, state
    );

    // Detector side.
    modport slave (
        input  car_in, EW,
        output x, queue_count, overflow, state
    );
endinterface

// File: rtl/side_road_detector.sv
// side_road_detector: conditions the side-road loop detector, counts waiting
// vehicles, retires them while the side road is green and raises x.
// Optional feature macro: DETECTOR_MAXWAIT_EN (a lone waiting vehicle only
// raises x after MAX_WAIT cycles in WAITING).
module side_road_detector #(
    parameter int DEBOUNCE      = 4,
    parameter int DEPART_CYCLES = 3,
    parameter int QW            = 4,
    parameter int MAX_WAIT      = 16
) (
    input  logic                 clk,
    input  logic                 clear,
    side_road_detector_if.slave  bus
);
    localparam logic [1:0] EW_GREEN   = 2'd2;
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_WAITING = 2'd1;
    localparam logic [1:0] ST_SERVING = 2'd2;

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam logic [QW-1:0] QMAX     = '1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] DEP_LAST = TW'(DEPART_CYCLES - 1);

    if (DEBOUNCE < 1 || DEPART_CYCLES < 1 || QW < 1 || MAX_WAIT < 1) begin : g_bad_params
        $error("side_road_detector: all parameters must be >= 1");
    end

    logic          sync_a, sync_b;
    logic          deb_level;
    logic [DW-1:0] deb_cnt;
    logic          deb_differs, deb_flip, arrival;
    logic          is_green, green_q, timing_ok, departure;
    logic [TW-1:0] dep_timer;
    logic [QW-1:0] queue_q, queue_next;
    logic          ovf_q, ovf_set;
    logic [1:0]    state_q, state_next;
    logic          x_q, x_next;

    // Two-flop synchronizer for the asynchronous loop input.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= bus.car_in;
            sync_b <= sync_a;
        end
    end

    // The debounced level flips on the DEBOUNCE-th consecutive differing cycle;
    // the flip itself is combinational so the queue updates on that same edge.
    assign deb_differs = (sync_b != deb_level);
    assign deb_flip    = deb_differs && (deb_cnt == DEB_LAST);
    assign arrival     = deb_flip && sync_b;

    // Debouncer: count differing cycles, restart on any return to the level.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (!deb_differs) begin
            deb_cnt <= '0;
        end else if (deb_flip) begin
            deb_level <= sync_b;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Codes 1 and 3 are both "not green", so YELLOW and the illegal code act as RED.
    // The first green cycle only qualifies the light; the departure timer
    // starts counting on the second, so departures land DEPART_CYCLES edges
    // after green is first seen.
    assign is_green  = (bus.EW == EW_GREEN);
    assign timing_ok = is_green && green_q && (queue_q != '0);
    assign departure = timing_ok && (dep_timer == DEP_LAST);

    // Departure timer: cleared off green or with an empty queue.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            green_q   <= 1'b0;
            dep_timer <= '0;
        end else begin
            green_q <= is_green;
            if (!timing_ok || departure)
                dep_timer <= '0;
            else
                dep_timer <= dep_timer + 1'b1;
        end
    end

    // Queue arithmetic: coincident arrival and departure cancel out.
    always_comb begin
        queue_next = queue_q;
        ovf_set    = 1'b0;
        if (arrival && !departure) begin
            if (queue_q == QMAX)
                ovf_set = 1'b1;
            else
                queue_next = queue_q + 1'b1;
        end else if (departure && !arrival) begin
            queue_next = queue_q - 1'b1;
        end
    end

    // Next state is decided purely by the post-update queue and the light.
    always_comb begin
        state_next = ST_WAITING;
        if (queue_next == '0)
            state_next = ST_EMPTY;
        else if (is_green)
            state_next = ST_SERVING;
    end

`ifdef DETECTOR_MAXWAIT_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_FIRE = WW'(MAX_WAIT - 1);
    logic [WW-1:0] wait_cnt;

    // Wait counter: runs only while staying in WAITING, saturates at MAX_WAIT.
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            wait_cnt <= '0;
        else if (state_q == ST_WAITING && state_next == ST_WAITING)
            wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Request: a lone waiting vehicle must wait out the starvation limit.
    always_comb begin
        x_next = (state_next != ST_EMPTY);
        if (state_next == ST_WAITING)
            x_next = (queue_next > QW'(1)) || (wait_cnt >= WAIT_FIRE);
    end
`else
    // Request: any queued vehicle asks for the side road.
    always_comb begin
        x_next = (state_next != ST_EMPTY);
    end
`endif

    // Output registers: queue, sticky overflow, FSM state and request together.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            queue_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= ST_EMPTY;
            x_q     <= 1'b0;
        end else begin
            queue_q <= queue_next;
            ovf_q   <= ovf_q | ovf_set;
            state_q <= state_next;
            x_q     <= x_next;
        end
    end

    assign bus.x           = x_q;
    assign bus.queue_count = queue_q;
    assign bus.overflow    = ovf_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_side_road_detector.sv
// tb_side_road_detector: two detectors (QW=4 and QW=2) share one stimulus
// stream; directed tables, hand sequences and random traffic are checked
// against an edge-level model of the queue behaviour.
module tb_side_road_detector;
    localparam int DEBOUNCE      = 4;
    localparam int DEPART_CYCLES = 3;
    localparam int MAX_WAIT      = 16;
    localparam logic [1:0] RED = 2'd0, GREEN = 2'd2;
    localparam logic [1:0] ST_EMPTY = 2'd0, ST_WAITING = 2'd1, ST_SERVING = 2'd2;
`ifdef DETECTOR_MAXWAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    typedef struct {
        logic       car;
        logic [1:0] ew;
        int         cycles;
        int         q4;
        int         q2;
        logic       ovf2;
        logic [1:0] st;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       car_in_r = 1'b0;
    logic [1:0] ew_r = 2'd0;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    side_road_detector_if #(.QW(4)) bus4 ();
    side_road_detector_if #(.QW(2)) bus2 ();
    assign bus4.car_in = car_in_r;
    assign bus4.EW     = ew_r;
    assign bus2.car_in = car_in_r;
    assign bus2.EW     = ew_r;

    side_road_detector #(.DEBOUNCE(DEBOUNCE), .DEPART_CYCLES(DEPART_CYCLES),
                         .QW(4), .MAX_WAIT(MAX_WAIT))
        dut4 (.clk(clk), .clear(clear), .bus(bus4));
    side_road_detector #(.DEBOUNCE(DEBOUNCE), .DEPART_CYCLES(DEPART_CYCLES),
                         .QW(2), .MAX_WAIT(MAX_WAIT))
        dut2 (.clk(clk), .clear(clear), .bus(bus2));

    // ---------------- reference model ----------------
    logic       hist[$];
    logic       deb;
    bit         prev_green;
    int         qmax[2] = '{15, 3};
    int         m_q[2];
    bit         m_ovf[2];
    bit         m_x[2];
    logic [1:0] m_st[2];
    int         served[2];
    int         waited[2];
    bit         all_diff, arrival, green, dep;
    logic [1:0] new_st;
    int         n;

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            hist.delete();
            for (int j = 0; j < DEBOUNCE + 2; j++) hist.push_back(1'b0);
            deb = 1'b0;
            prev_green = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_q[i] = 0; m_ovf[i] = 0; m_x[i] = 0; m_st[i] = ST_EMPTY;
                served[i] = 0; waited[i] = 0;
            end
        end else begin
            // Debouncer sees car_in two edges late; it flips when the last
            // DEBOUNCE seen values all disagree with the accepted level.
            hist.push_back(car_in_r);
            n = hist.size();
            all_diff = 1'b1;
            for (int j = 0; j < DEBOUNCE; j++)
                if (hist[n - 3 - j] == deb) all_diff = 1'b0;
            arrival = all_diff && !deb;
            if (all_diff) deb = ~deb;
            void'(hist.pop_front());
            green = (ew_r == GREEN);
            for (int i = 0; i < 2; i++) begin
                dep = 1'b0;
                if (green && prev_green && m_q[i] > 0) served[i]++;
                else served[i] = 0;
                if (served[i] == DEPART_CYCLES) begin
                    dep = 1'b1;
                    served[i] = 0;
                end
                if (arrival && !dep) begin
                    if (m_q[i] == qmax[i]) m_ovf[i] = 1'b1;
                    else m_q[i]++;
                end else if (dep && !arrival) begin
                    m_q[i]--;
                end
                new_st = (m_q[i] == 0) ? ST_EMPTY : (green ? ST_SERVING : ST_WAITING);
                m_x[i] = (new_st != ST_EMPTY);
                if (MW && new_st == ST_WAITING)
                    m_x[i] = (m_q[i] >= 2) || (m_st[i] == ST_WAITING && waited[i] >= MAX_WAIT - 1);
                waited[i] = (m_st[i] == ST_WAITING && new_st == ST_WAITING) ? waited[i] + 1 : 0;
                m_st[i] = new_st;
            end
            prev_green = green;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of both DUTs against the model, away from posedge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q4",   int'(bus4.queue_count), m_q[0]);
            check("model_x4",   int'(bus4.x),           int'(m_x[0]));
            check("model_st4",  int'(bus4.state),       int'(m_st[0]));
            check("model_ovf4", int'(bus4.overflow),    int'(m_ovf[0]));
            check("model_q2",   int'(bus2.queue_count), m_q[1]);
            check("model_x2",   int'(bus2.x),           int'(m_x[1]));
            check("model_st2",  int'(bus2.state),       int'(m_st[1]));
            check("model_ovf2", int'(bus2.overflow),    int'(m_ovf[1]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic c, input logic [1:0] e);
        #1;
        car_in_r = c;
        ew_r = e;
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic check_q(input string name, input int exp4, input int exp2);
        check({name, "_q4"}, int'(bus4.queue_count), exp4);
        check({name, "_q2"}, int'(bus2.queue_count), exp2);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[$];
    logic car_lvl;
    logic [1:0] ew_lvl;

    initial begin
        // Directed table, starting with one car queued and car_in still high.
        vecs.push_back(vec_t'{1'b0, RED,   8, 1, 1, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b1, RED,   3, 1, 1, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b0, RED,   8, 1, 1, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b1, RED,   6, 2, 2, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b0, RED,   6, 2, 2, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b1, RED,   6, 3, 3, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b0, RED,   6, 3, 3, 1'b0, ST_WAITING});
        vecs.push_back(vec_t'{1'b0, GREEN, 3, 3, 3, 1'b0, ST_SERVING});
        vecs.push_back(vec_t'{1'b0, GREEN, 1, 2, 2, 1'b0, ST_SERVING});
        vecs.push_back(vec_t'{1'b0, GREEN, 3, 1, 1, 1'b0, ST_SERVING});
        vecs.push_back(vec_t'{1'b0, GREEN, 3, 0, 0, 1'b0, ST_EMPTY});
        for (int i = 1; i <= 5; i++) begin
            vecs.push_back(vec_t'{1'b1, RED, 6, i, (i > 3) ? 3 : i, logic'(i > 3), ST_WAITING});
            vecs.push_back(vec_t'{1'b0, RED, 6, i, (i > 3) ? 3 : i, logic'(i > 3), ST_WAITING});
        end
        vecs.push_back(vec_t'{1'b0, GREEN, 16, 0, 0, 1'b1, ST_EMPTY});

        // Reset held with car_in high: everything stays zero.
        #2;
        clear = 1'b1;
        car_in_r = 1'b1;
        ew_r = RED;
        chk_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_q",   int'(bus4.queue_count), 0);
            check("rst_x",   int'(bus4.x), 0);
            check("rst_st",  int'(bus4.state), int'(ST_EMPTY));
            check("rst_ovf", int'(bus4.overflow), 0);
        end
        #1 clear = 1'b0;
        tick(5);
        check("rel_before_q", int'(bus4.queue_count), 0);
        check("rel_before_x", int'(bus4.x), 0);
        tick(1);
        check("rel_arrive_q", int'(bus4.queue_count), 1);
        check("rel_arrive_x", int'(bus4.x), int'(!MW));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].car, vecs[i].ew);
            tick(vecs[i].cycles);
            check_q($sformatf("tbl%0d", i), vecs[i].q4, vecs[i].q2);
            check($sformatf("tbl%0d_st", i),   int'(bus4.state),    int'(vecs[i].st));
            check($sformatf("tbl%0d_ovf2", i), int'(bus2.overflow), int'(vecs[i].ovf2));
            check($sformatf("tbl%0d_ovf4", i), int'(bus4.overflow), 0);
`ifndef DETECTOR_MAXWAIT_EN
            check($sformatf("tbl%0d_x", i), int'(bus4.x), int'(vecs[i].st != ST_EMPTY));
`endif
        end

        // Arrival lands on the same edge as a departure: count holds at 2.
        drive(1'b1, RED); tick(6);
        drive(1'b0, RED); tick(6);
        drive(1'b1, RED); tick(6);
        drive(1'b0, RED); tick(6);
        check_q("simul_setup", 2, 2);
        drive(1'b1, RED);   tick(2);
        drive(1'b1, GREEN); tick(3);
        check_q("simul_pre", 2, 2);
        tick(1);
        check_q("simul_edge", 2, 2);
        drive(1'b0, GREEN); tick(6);
        check_q("simul_drain", 0, 0);
        check("simul_drain_st", int'(bus4.state), int'(ST_EMPTY));
        check("simul_drain_x",  int'(bus4.x), 0);
        check("sticky_ovf2",    int'(bus2.overflow), 1);

        // clear discards the sticky overflow.
        #1 clear = 1'b1;
        tick(2);
        check("clr_ovf2", int'(bus2.overflow), 0);
        #1 clear = 1'b0;

        // Glitch shorter than DEBOUNCE from an empty queue.
        drive(1'b1, RED); tick(3);
        drive(1'b0, RED); tick(10);
        check_q("glitch", 0, 0);
        check("glitch_x", int'(bus4.x), 0);

        // Random traffic against the model, with one mid-run clear.
        car_lvl = 1'b0;
        ew_lvl = RED;
        for (int it = 0; it < 160; it++) begin
            car_lvl = ~car_lvl;
            if ($urandom_range(0, 3) == 0) ew_lvl = 2'($urandom_range(0, 3));
            drive(car_lvl, ew_lvl);
            tick($urandom_range(1, 9));
            if (it == 80) begin
                #1 clear = 1'b1;
                tick(1);
                #1 clear = 1'b0;
            end
        end

`ifdef DETECTOR_MAXWAIT_EN
        #1 clear = 1'b1;
        car_in_r = 1'b0;
        ew_r = RED;
        tick(2);
        #1 clear = 1'b0;
        // Lone vehicle: x rises 16 edges after entering WAITING.
        drive(1'b1, RED); tick(6);
        check("mw_one_q", int'(bus4.queue_count), 1);
        check("mw_one_x0", int'(bus4.x), 0);
        drive(1'b0, RED); tick(9);
        check("mw_one_x9", int'(bus4.x), 0);
        tick(6);
        check("mw_one_x15", int'(bus4.x), 0);
        tick(1);
        check("mw_one_x16", int'(bus4.x), 1);
        drive(1'b0, GREEN); tick(4);
        check("mw_drain_q", int'(bus4.queue_count), 0);
        // Second arrival before the limit raises x on its own edge.
        drive(1'b1, RED); tick(6);
        check("mw_two_x0", int'(bus4.x), 0);
        drive(1'b0, RED); tick(6);
        drive(1'b1, RED); tick(5);
        check("mw_two_pre_q", int'(bus4.queue_count), 1);
        check("mw_two_pre_x", int'(bus4.x), 0);
        tick(1);
        check("mw_two_q", int'(bus4.queue_count), 2);
        check("mw_two_x", int'(bus4.x), 1);
`endif

        tick(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
